// File: rtl/acc_pkg.sv
// Shared types and default geometry for the accelerator frame serializer/deserializer.
package acc_pkg;

  localparam int unsigned ACC_NPOINTS  = 64;
  localparam int unsigned ACC_SAMPLE_W = 32;
  localparam int unsigned ACC_BUS_W    = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/acc_beat_mux.sv
// Selects one BUS_W-wide beat out of a flat frame by beat index.
module acc_beat_mux #(
  parameter int unsigned FRAME_BITS = 4096,
  parameter int unsigned BUS_W      = 64,
  parameter int unsigned IDX_W      = 7
) (
  input  logic [IDX_W-1:0]      index,
  input  logic [FRAME_BITS-1:0] frame,
  output logic [BUS_W-1:0]      beat
);

  localparam int unsigned NBEATS = FRAME_BITS / BUS_W;

  // Table padded to the full index range so the lookup needs no width adaptation.
  logic [BUS_W-1:0] beats [2**IDX_W];

  for (genvar g = 0; g < 2**IDX_W; g++) begin : g_beat
    if (g < NBEATS) begin : g_used
      assign beats[g] = frame[g*BUS_W +: BUS_W];
    end else begin : g_pad
      assign beats[g] = '0;
    end
  end

  assign beat = beats[index];

endmodule

// File: rtl/acc_frame_serdes.sv
// Loads a complex frame (stream or wide port), runs it through an external engine
// (or bypasses it) and emits the result frame (stream or wide port).
module acc_frame_serdes
  import acc_pkg::*;
#(
  parameter int unsigned NPOINTS  = ACC_NPOINTS,
  parameter int unsigned SAMPLE_W = ACC_SAMPLE_W,
  parameter int unsigned BUS_W    = ACC_BUS_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_bypass,
  input  logic                            cfg_fwd_in,
  input  logic                            cfg_fwd_out,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BUS_W-1:0]                in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BUS_W-1:0]                out_data,
  input  logic                            fwd_in_valid,
  output logic                            fwd_in_ready,
  input  logic [2*NPOINTS*SAMPLE_W-1:0]   fwd_in_data,
  output logic                            fwd_out_valid,
  input  logic                            fwd_out_ready,
  output logic [2*NPOINTS*SAMPLE_W-1:0]   fwd_out_data,
  output logic                            eng_start,
  output logic [NPOINTS*SAMPLE_W-1:0]     eng_real,
  output logic [NPOINTS*SAMPLE_W-1:0]     eng_imag,
  input  logic                            eng_done,
  input  logic [NPOINTS*SAMPLE_W-1:0]     eng_real_res,
  input  logic [NPOINTS*SAMPLE_W-1:0]     eng_imag_res,
  output logic                            busy
);

  localparam int unsigned SPB     = BUS_W / SAMPLE_W;
  localparam int unsigned BEATS   = 2 * NPOINTS / SPB;
  localparam int unsigned FRAME_W = NPOINTS * SAMPLE_W;
  localparam int unsigned CNT_W   = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  if ((BUS_W % SAMPLE_W) != 0 || ((2 * NPOINTS) % SPB) != 0) begin : g_bad_geometry
    $error("acc_frame_serdes: BUS_W must hold whole samples and a frame whole beats");
  end

  state_t state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 bypass_q, fwd_in_q, fwd_out_q;
  logic [2*FRAME_W-1:0] load_q, load_d;
  logic [2*FRAME_W-1:0] res_q, res_d;
  logic [BUS_W-1:0]     beat_d;
  logic                 in_we, fwd_we, loaded, eng_take;

  // Flat frame layout: sample i at bits [i*SAMPLE_W +: SAMPLE_W], i.e. {real, imag}.
  for (genvar g = 0; g < BEATS; g++) begin : g_load
    assign load_d[g*BUS_W +: BUS_W] =
      fwd_we                          ? fwd_in_data[g*BUS_W +: BUS_W] :
      (in_we && cnt_q == CNT_W'(g))   ? in_data :
                                        load_q[g*BUS_W +: BUS_W];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_ready     = 1'b0;
    fwd_in_ready = 1'b0;
    in_we        = 1'b0;
    fwd_we       = 1'b0;
    loaded       = 1'b0;
    eng_take     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_fwd_in ? fwd_in_valid : in_valid) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (fwd_in_q) begin
          fwd_in_ready = 1'b1;
          if (fwd_in_valid) begin
            fwd_we = 1'b1;
            loaded = 1'b1;
          end
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            in_we = 1'b1;
            if (cnt_q == LAST) loaded = 1'b1;
            else               cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        if (loaded) begin
          cnt_d   = '0;
          state_d = bypass_q ? S_DRAIN : S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          eng_take = 1'b1;
          cnt_d    = '0;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fwd_out_q) begin
          if (fwd_out_ready) state_d = S_IDLE;
        end else if (out_ready) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    res_d = res_q;
    if (loaded && bypass_q) res_d = load_d;
    else if (eng_take)      res_d = {eng_real_res, eng_imag_res};
  end

  // Beat for the next drain cycle is looked up from next-state values, so the
  // first beat is already registered on the cycle the drain begins.
  acc_beat_mux #(
    .FRAME_BITS(2 * FRAME_W),
    .BUS_W     (BUS_W),
    .IDX_W     (CNT_W)
  ) u_beat_mux (
    .index(cnt_d),
    .frame(res_d),
    .beat (beat_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bypass_q  <= 1'b0;
      fwd_in_q  <= 1'b0;
      fwd_out_q <= 1'b0;
      load_q    <= '0;
      res_q     <= '0;
      out_data  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      res_q   <= res_d;
      if (state_q == S_IDLE && state_d == S_LOAD) begin
        bypass_q  <= cfg_bypass;
        fwd_in_q  <= cfg_fwd_in;
        fwd_out_q <= cfg_fwd_out;
      end
      if (state_d == S_DRAIN) out_data <= beat_d;
    end
  end

  assign out_valid     = (state_q == S_DRAIN) && !fwd_out_q;
  assign fwd_out_valid = (state_q == S_DRAIN) && fwd_out_q;
  assign fwd_out_data  = res_q;
  assign eng_start     = (state_q == S_START);
  assign eng_real      = load_q[2*FRAME_W-1 -: FRAME_W];
  assign eng_imag      = load_q[FRAME_W-1:0];
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_acc_frame_serdes.sv
// Self-checking bench for acc_frame_serdes against a sample-level reference model.
module tb_acc_frame_serdes;

  localparam int NP    = 64;
  localparam int SW    = 32;
  localparam int BW    = 64;
  localparam int SPB   = BW / SW;
  localparam int BEATS = 2 * NP / SPB;
  localparam int FW    = NP * SW;

  logic clk, rst;
  logic cfg_bypass, cfg_fwd_in, cfg_fwd_out;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [BW-1:0] in_data, out_data;
  logic fwd_in_valid, fwd_in_ready, fwd_out_valid, fwd_out_ready;
  logic [2*FW-1:0] fwd_in_data, fwd_out_data;
  logic eng_start, eng_done, busy;
  logic [FW-1:0] eng_real, eng_imag, eng_real_res, eng_imag_res;

  acc_frame_serdes #(.NPOINTS(NP), .SAMPLE_W(SW), .BUS_W(BW)) dut (
    .clk(clk), .rst(rst),
    .cfg_bypass(cfg_bypass), .cfg_fwd_in(cfg_fwd_in), .cfg_fwd_out(cfg_fwd_out),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fwd_in_valid(fwd_in_valid), .fwd_in_ready(fwd_in_ready), .fwd_in_data(fwd_in_data),
    .fwd_out_valid(fwd_out_valid), .fwd_out_ready(fwd_out_ready), .fwd_out_data(fwd_out_data),
    .eng_start(eng_start), .eng_real(eng_real), .eng_imag(eng_imag),
    .eng_done(eng_done), .eng_real_res(eng_real_res), .eng_imag_res(eng_imag_res),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference frame as a plain list of samples: index 0..NP-1 imag, NP..2NP-1 real.
  logic [SW-1:0] src [$];
  logic [BW-1:0] outq [$];
  logic [2*FW-1:0] fwdq [$];
  logic [2*FW-1:0] eng_cap, eng_res_v;
  int eng_delta = 0;
  int ready_mode = 0;
  int stale_req_cnt = 0;
  int stale_done_cnt = 0;

  int cyc = 0;
  int start_cnt = 0, hold_err = 0, stream_act = 0;
  int last_in_cyc = -1, out_rise_cyc = -1;
  logic held = 1'b0, prev_out_valid = 1'b0;
  logic [BW-1:0] held_data;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observation of DUT ports, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      held = 1'b0;
      prev_out_valid = 1'b0;
    end else begin
      if (eng_start) start_cnt++;
      if (in_valid && in_ready) last_in_cyc = cyc;
      if (out_valid && !prev_out_valid) out_rise_cyc = cyc;
      if (held && out_data !== held_data) hold_err++;
      if (out_valid && out_ready) outq.push_back(out_data);
      if (fwd_out_valid && fwd_out_ready) fwdq.push_back(fwd_out_data);
      if (in_ready || out_valid) stream_act++;
      held = out_valid && !out_ready;
      held_data = out_data;
      prev_out_valid = out_valid;
    end
  end

  initial begin
    out_ready = 1'b0;
    fwd_out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      fwd_out_ready = ($urandom_range(0, 2) == 0);
    end
  end

  // Engine model: result = loaded frame + eng_delta per sample, 5 cycles after start.
  initial begin
    eng_done = 1'b0;
    eng_real_res = '0;
    eng_imag_res = '0;
    forever begin
      @(negedge clk);
      if (stale_req_cnt != stale_done_cnt) begin
        stale_done_cnt++;
        @(posedge clk); #1;
        {eng_real_res, eng_imag_res} = '1;
        eng_done = 1'b1;
        @(posedge clk); #1;
        eng_done = 1'b0;
      end else if (eng_start && !rst) begin
        eng_cap = {eng_real, eng_imag};
        for (int i = 0; i < 2*NP; i++)
          eng_res_v[i*SW +: SW] = eng_cap[i*SW +: SW] + SW'(eng_delta);
        repeat (5) @(posedge clk);
        #1;
        {eng_real_res, eng_imag_res} = eng_res_v;
        eng_done = 1'b1;
        @(posedge clk); #1;
        eng_done = 1'b0;
      end
    end
  end

  function automatic logic [BW-1:0] src_beat(int n, int delta);
    logic [BW-1:0] b = '0;
    for (int k = 0; k < SPB; k++) b[k*SW +: SW] = src[n*SPB + k] + SW'(delta);
    return b;
  endfunction

  function automatic logic [2*FW-1:0] src_frame(int delta);
    logic [2*FW-1:0] f = '0;
    for (int i = 0; i < 2*NP; i++) f[i*SW +: SW] = src[i] + SW'(delta);
    return f;
  endfunction

  function automatic int first_diff(logic [2*FW-1:0] a, logic [2*FW-1:0] b);
    for (int i = 0; i < 2*NP; i++) if (a[i*SW +: SW] !== b[i*SW +: SW]) return i;
    return 0;
  endfunction

  task automatic new_src(int frames, bit counting);
    src.delete();
    for (int i = 0; i < frames*2*NP; i++) src.push_back(counting ? SW'(i) : SW'($urandom));
  endtask

  task automatic set_cfg(logic byp, logic fin, logic fout);
    cfg_bypass = byp;
    cfg_fwd_in = fin;
    cfg_fwd_out = fout;
  endtask

  task automatic drive_beats(int nbeats, bit gaps);
    int n = 0;
    int guard = 0;
    bit hs;
    while (n < nbeats && guard < 20*nbeats + 200) begin
      if (gaps && $urandom_range(0, 3) == 0) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data = src_beat(n, 0);
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) n++;
      guard++;
    end
    in_valid = 1'b0;
    if (n < nbeats) begin
      n_checks++; n_fail++;
      $display("FAIL drive_timeout: accepted %0d beats, required %0d", n, nbeats);
    end
  endtask

  task automatic wait_out(int target, int budget);
    int t = 0;
    while (outq.size() < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (outq.size() < target) begin
      n_checks++; n_fail++;
      $display("FAIL out_timeout: got %0d beats, required %0d", outq.size(), target);
    end
  endtask

  task automatic wait_idle(int budget);
    int t = 0;
    while (busy && t < budget) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic check_beats(string name, int base, int nbeats, int delta);
    for (int n = 0; n < nbeats; n++) begin
      n_checks++;
      if (base + n >= outq.size()) begin
        n_fail++;
        $display("FAIL %s[%0d]: beat missing, required %h", name, n, src_beat(n, delta));
      end else if (outq[base + n] !== src_beat(n, delta)) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h, required %h", name, n, outq[base + n], src_beat(n, delta));
      end
    end
  endtask

  task automatic check_reset_outputs(string name);
    n_checks++;
    if ({in_ready, fwd_in_ready, out_valid, fwd_out_valid, eng_start, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL %s_ctrl: got %b, required 000000", name,
               {in_ready, fwd_in_ready, out_valid, fwd_out_valid, eng_start, busy});
    end
    n_checks++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL %s_out_data: got %h, required 0", name, out_data);
    end
    n_checks++;
    if (fwd_out_data !== '0) begin
      n_fail++;
      $display("FAIL %s_fwd_out_data: sample %0d nonzero, required 0", name,
               first_diff(fwd_out_data, '0));
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_engine_echo;
    int base = outq.size();
    int s0 = start_cnt;
    new_src(1, 1'b1);
    set_cfg(1'b0, 1'b0, 1'b0);
    eng_delta = 0;
    ready_mode = 0;
    drive_beats(BEATS, 1'b0);
    wait_out(base + BEATS, 2000);
    wait_idle(200);
    n_checks++;
    if (outq.size() - base !== BEATS) begin
      n_fail++;
      $display("FAIL echo_count: got %0d beats, required %0d", outq.size() - base, BEATS);
    end
    n_checks++;
    if (start_cnt - s0 !== 1) begin
      n_fail++;
      $display("FAIL echo_starts: got %0d, required 1", start_cnt - s0);
    end
    n_checks++;
    if (eng_cap !== src_frame(0)) begin
      n_fail++;
      $display("FAIL echo_eng_frame: sample %0d got %h, required %h", first_diff(eng_cap, src_frame(0)),
               eng_cap[first_diff(eng_cap, src_frame(0))*SW +: SW], src[first_diff(eng_cap, src_frame(0))]);
    end
    check_beats("echo_beat", base, BEATS, 0);
  endtask

  task automatic test_bypass;
    int base = outq.size();
    int s0 = start_cnt;
    logic [BW-1:0] first_exp;
    new_src(1, 1'b1);
    first_exp = {32'd1, 32'd0};
    set_cfg(1'b1, 1'b0, 1'b0);
    ready_mode = 0;
    drive_beats(BEATS, 1'b1);
    wait_out(base + BEATS, 2000);
    wait_idle(200);
    n_checks++;
    if (start_cnt - s0 !== 0) begin
      n_fail++;
      $display("FAIL bypass_starts: got %0d, required 0", start_cnt - s0);
    end
    n_checks++;
    if (out_rise_cyc !== last_in_cyc + 1) begin
      n_fail++;
      $display("FAIL bypass_latency: first out cycle %0d, required %0d", out_rise_cyc, last_in_cyc + 1);
    end
    n_checks++;
    if (outq.size() <= base || outq[base] !== first_exp) begin
      n_fail++;
      $display("FAIL bypass_first_beat: got %h, required %h", outq.size() > base ? outq[base] : '0, first_exp);
    end
    check_beats("bypass_beat", base, BEATS, 0);
  endtask

  task automatic test_backpressure;
    int base = outq.size();
    int h0 = hold_err;
    new_src(1, 1'b0);
    set_cfg(1'b0, 1'b0, 1'b0);
    eng_delta = 0;
    ready_mode = 1;
    drive_beats(BEATS, 1'b1);
    wait_out(base + BEATS, 3000);
    wait_idle(200);
    n_checks++;
    if (outq.size() - base !== BEATS) begin
      n_fail++;
      $display("FAIL bp_count: got %0d handshakes, required %0d", outq.size() - base, BEATS);
    end
    n_checks++;
    if (hold_err - h0 !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d unstable cycles, required 0", hold_err - h0);
    end
    check_beats("bp_beat", base, BEATS, 0);
    ready_mode = 0;
  endtask

  task automatic test_forward;
    int base = fwdq.size();
    int s0 = start_cnt;
    int a0 = stream_act;
    int t = 0;
    bit hs = 1'b0;
    logic [2*FW-1:0] exp_f;
    new_src(1, 1'b0);
    exp_f = src_frame(1);
    set_cfg(1'b0, 1'b1, 1'b1);
    eng_delta = 1;
    fwd_in_data = src_frame(0);
    fwd_in_valid = 1'b1;
    while (!hs && t < 50) begin
      @(negedge clk);
      hs = fwd_in_valid && fwd_in_ready;
      @(posedge clk); #1;
      t++;
    end
    fwd_in_valid = 1'b0;
    t = 0;
    while (fwdq.size() <= base && t < 500) begin
      @(posedge clk);
      t++;
    end
    wait_idle(200);
    n_checks++;
    if (fwdq.size() - base !== 1) begin
      n_fail++;
      $display("FAIL fwd_count: got %0d handshakes, required 1", fwdq.size() - base);
    end
    n_checks++;
    if (fwdq.size() <= base) begin
      n_fail++;
      $display("FAIL fwd_frame: no frame, required sample0 %h", exp_f[SW-1:0]);
    end else if (fwdq[base] !== exp_f) begin
      n_fail++;
      $display("FAIL fwd_frame: sample %0d got %h, required %h", first_diff(fwdq[base], exp_f),
               fwdq[base][first_diff(fwdq[base], exp_f)*SW +: SW], exp_f[first_diff(fwdq[base], exp_f)*SW +: SW]);
    end
    n_checks++;
    if (stream_act - a0 !== 0) begin
      n_fail++;
      $display("FAIL fwd_stream_idle: got %0d active cycles, required 0", stream_act - a0);
    end
    n_checks++;
    if (start_cnt - s0 !== 1) begin
      n_fail++;
      $display("FAIL fwd_starts: got %0d, required 1", start_cnt - s0);
    end
    set_cfg(1'b0, 1'b0, 1'b0);
    eng_delta = 0;
  endtask

  task automatic test_reset_mid;
    int base = outq.size();
    int s0 = start_cnt;
    new_src(1, 1'b0);
    set_cfg(1'b0, 1'b0, 1'b0);
    ready_mode = 2;
    drive_beats(30, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    stale_req_cnt++;
    repeat (6) @(posedge clk); #1;
    n_checks++;
    if ({busy, out_valid, fwd_out_valid} !== 3'b0) begin
      n_fail++;
      $display("FAIL stale_done: busy/out_valid/fwd_out_valid got %b, required 000",
               {busy, out_valid, fwd_out_valid});
    end
    n_checks++;
    if (outq.size() - base !== 0 || start_cnt - s0 !== 0) begin
      n_fail++;
      $display("FAIL midreset_leak: beats %0d starts %0d, required 0 0", outq.size() - base, start_cnt - s0);
    end
    new_src(1, 1'b0);
    drive_beats(BEATS, 1'b1);
    wait_out(base + BEATS, 3000);
    wait_idle(200);
    check_beats("postreset_beat", base, BEATS, 0);
    ready_mode = 0;
  endtask

  task automatic test_back_to_back;
    int base = outq.size();
    new_src(2, 1'b0);
    set_cfg(1'b1, 1'b0, 1'b0);
    ready_mode = 0;
    drive_beats(2*BEATS, 1'b0);
    wait_out(base + 2*BEATS, 3000);
    wait_idle(200);
    n_checks++;
    if (outq.size() - base !== 2*BEATS) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d beats, required %0d", outq.size() - base, 2*BEATS);
    end
    check_beats("b2b_beat", base, 2*BEATS, 0);
    set_cfg(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_cfg(1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    in_data = '0;
    fwd_in_valid = 1'b0;
    fwd_in_data = '0;
    test_reset();
    test_engine_echo();
    test_bypass();
    test_backpressure();
    test_forward();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_frame_serdes.md
ACC_FRAME_SERDES -- requirements
Module: acc_frame_serdes

Interface
REQ-001 Parameter NPOINTS, default 64: complex samples per frame.
REQ-002 Parameter SAMPLE_W, default 32: bits per real or imag sample.
REQ-003 Parameter BUS_W, default 64: stream beat width; SPB = BUS_W/SAMPLE_W samples per beat; BEATS = 2*NPOINTS/SPB beats per frame; FRAME_W = NPOINTS*SAMPLE_W.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_bypass  in  1  1 = skip engine; output frame = loaded frame.
REQ-007 cfg_fwd_in  in  1  1 = load frame from fwd_in_* instead of stream.
REQ-008 cfg_fwd_out  in  1  1 = emit frame on fwd_out_* instead of stream.
REQ-009 in_valid / in_ready / in_data  in / out / BUS_W  consumer stream.
REQ-010 out_valid / out_ready / out_data  out / in / BUS_W  producer stream.
REQ-011 fwd_in_valid / fwd_in_ready / fwd_in_data  in / out / 2*FRAME_W  wide frame in, {real, imag}.
REQ-012 fwd_out_valid / fwd_out_ready / fwd_out_data  out / in / 2*FRAME_W  wide frame out, {real, imag}.
REQ-013 eng_start  out  1  one-cycle pulse; eng_real / eng_imag  out  FRAME_W each  loaded frame.
REQ-014 eng_done  in  1  one-cycle pulse; eng_real_res / eng_imag_res  in  FRAME_W each  sampled on eng_done.
REQ-015 busy  out  1  high whenever state != S_IDLE.

Function
REQ-016 States: S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN.
REQ-017 cfg_* latched on the cycle S_IDLE exits; they are ignored mid-frame.
REQ-018 S_IDLE -> S_LOAD when in_valid (cfg_fwd_in=0) or fwd_in_valid (cfg_fwd_in=1); the beat counter clears to 0.
REQ-019 S_LOAD stream: in_ready=1; each in_valid&in_ready beat n writes its SPB lanes (lane k = in_data[k*SAMPLE_W +: SAMPLE_W]) to sample index n*SPB+k; indices 0..NPOINTS-1 go to imag, NPOINTS..2*NPOINTS-1 go to real.
REQ-020 S_LOAD forward: fwd_in_ready=1 for one cycle and the whole frame loads in that cycle.
REQ-021 When the beat at counter=BEATS-1 is accepted, the next state is S_START; when cfg_bypass=1 it is S_DRAIN directly, with the result registers copied from the load registers.
REQ-022 S_START: eng_start=1 for exactly one cycle, then S_WAIT.
REQ-023 S_WAIT: hold until eng_done; result registers capture eng_*_res; then S_DRAIN with the counter at 0. An eng_done outside S_WAIT is ignored.
REQ-024 S_DRAIN stream: out_valid=1; out_data is registered from the result at beat order identical to REQ-019; out_data is held stable while out_valid&!out_ready; the counter advances only on out_valid&out_ready.
REQ-025 S_DRAIN forward: fwd_out_valid=1 until fwd_out_ready, with fwd_out_data = {real, imag}; then S_IDLE.
REQ-026 The handshake on the last stream beat (counter=BEATS-1) returns to S_IDLE; a new frame may start on the next cycle.
REQ-027 in_ready=0 and fwd_in_ready=0 outside S_LOAD; out_valid=0 and fwd_out_valid=0 outside S_DRAIN; there is no frame overlap.
REQ-028 The counter width is $clog2(BEATS)+1, and the counter never wraps within a frame.

Reset
REQ-029 While rst is high: state=S_IDLE, counter=0, all valid/ready/eng_start/busy outputs are 0, and out_data/fwd_out_data are 0.
REQ-030 A reset asserted mid-frame discards the partial frame and any in-flight engine result; an eng_done pulse after reset is ignored.

Structure
REQ-031 The state_t enum and the default NPOINTS/SAMPLE_W/BUS_W constants reside in acc_pkg.
REQ-032 The per-beat lane pack/unpack is one sub-module, acc_beat_mux (index, frame -> beat), used for the drain path.
REQ-033 An elaboration-time check fails when BUS_W % SAMPLE_W != 0 or (2*NPOINTS) % SPB != 0.

Verification
REQ-034 Defaults, cfg=000: 64 beats, beat n = {n*2+1, n*2}; engine echoes the frame with eng_done 5 cycles after start -> 64 out beats, identical order and values, and eng_start pulses once.
REQ-035 cfg_bypass=1: same input -> no eng_start; the first out beat {1,0} appears on the cycle after the last input beat is accepted.
REQ-036 out_ready toggles 1,0,0,1 during the drain -> out_data is held and no beat is lost or duplicated; exactly 64 handshakes occur.
REQ-037 cfg_fwd_in=1, cfg_fwd_out=1, engine result = frame+1 per sample -> one fwd_out handshake carrying the incremented frame; the stream ports stay idle.
REQ-038 rst pulsed at load beat 30 -> the outputs go to their reset values; the next full frame is output uncorrupted, and a stale eng_done is ignored.
